// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a one-entry holding register.
// Frame = start bit, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits,
// each bit BAUD_DIV clocks long. A queued word is loaded at the final stop-bit edge,
// so consecutive frames run with no idle gap on the line.
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 110,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              TX,
    output logic              tx_rdy,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    // Bit counter covers the data bits and, reused, the stop bits (DATA_W >= 5 > STOP_BITS).
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              PARITY_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                parity_reg, parity_next;
    logic [DATA_W-1:0]   hold_reg, hold_next;
    logic                hold_full_reg, hold_full_next;
    logic                tx_reg, tx_next;
    logic                busy_reg, busy_next;
    logic                tx_done_reg, tx_done_next;

    logic                bit_end;
    logic                load;
    logic                accept;
    logic [DATA_W-1:0]   shift_right;

    // Shift register moved one place towards bit 0; vacated top bit fills with idle level.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == DATA_W - 1) begin : g_top
                assign shift_right[gi] = 1'b1;
            end else begin : g_low
                assign shift_right[gi] = shift_reg[gi + 1];
            end
        end
    endgenerate

    // Next-state logic: bit timing, frame sequencing, hold-register load/accept, line value.
    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        tx_done_next   = 1'b0;
        tx_next        = 1'b1;
        busy_next      = 1'b0;
        load           = 1'b0;
        bit_end        = (baud_cnt_reg == BAUD_LAST);
        accept         = trmt && !hold_full_reg;

        if (state_reg != IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (hold_full_reg) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == DATA_LAST) begin
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_right;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    bit_cnt_next = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        tx_done_next = 1'b1;
                        if (hold_full_reg) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A load needs a full hold register and an accept needs an empty one,
        // so the two are mutually exclusive.
        if (load) begin
            state_next     = START;
            baud_cnt_next  = '0;
            bit_cnt_next   = '0;
            shift_next     = hold_reg;
            parity_next    = (^hold_reg) ^ PARITY_INV;
            hold_full_next = 1'b0;
        end else if (accept) begin
            hold_next      = tx_data;
            hold_full_next = 1'b1;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset discards in-flight and queued words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            tx_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
            tx_done_reg   <= tx_done_next;
        end
    end

    assign TX      = tx_reg;
    assign tx_rdy  = !hold_full_reg;
    assign busy    = busy_reg;
    assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: six transmitter configurations driven side by side. A per-cycle
// reference model (frame position arithmetic over a queued word) predicts TX, busy,
// tx_rdy and tx_done; directed frames are also checked against literal bit patterns.
module tb_uart_tx_cfg;

    localparam int NU = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NU-1:0] trmt_v = '0;
    logic [8:0]    data_v [NU];
    logic [NU-1:0] tx_v, rdy_v, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .trmt(trmt_v[0]), .tx_data(data_v[0][7:0]),
        .TX(tx_v[0]), .tx_rdy(rdy_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .trmt(trmt_v[1]), .tx_data(data_v[1][7:0]),
        .TX(tx_v[1]), .tx_rdy(rdy_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .trmt(trmt_v[2]), .tx_data(data_v[2][7:0]),
        .TX(tx_v[2]), .tx_rdy(rdy_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_cfg #(.DATA_W(7), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .trmt(trmt_v[3]), .tx_data(data_v[3][6:0]),
        .TX(tx_v[3]), .tx_rdy(rdy_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));
    uart_tx_cfg #(.DATA_W(9), .BAUD_DIV(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut4 (
        .clk(clk), .rst(rst), .trmt(trmt_v[4]), .tx_data(data_v[4]),
        .TX(tx_v[4]), .tx_rdy(rdy_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]));
    uart_tx_cfg #(.DATA_W(5), .BAUD_DIV(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut5 (
        .clk(clk), .rst(rst), .trmt(trmt_v[5]), .tx_data(data_v[5][4:0]),
        .TX(tx_v[5]), .tx_rdy(rdy_v[5]), .busy(busy_v[5]), .tx_done(done_v[5]));

    // Per-unit configuration, matching the instances above.
    function automatic int cfg_dw(int u);
        case (u)
            3: return 7;
            4: return 9;
            5: return 5;
            default: return 8;
        endcase
    endfunction
    function automatic int cfg_bd(int u);
        case (u)
            4: return 2;
            5: return 5;
            default: return 16;
        endcase
    endfunction
    function automatic int cfg_pe(int u);
        return (u == 1 || u == 2 || u == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_po(int u);
        return (u == 2 || u == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(int u);
        return (u == 3 || u == 4) ? 2 : 1;
    endfunction
    function automatic int cfg_nbits(int u);
        return 1 + cfg_dw(u) + cfg_pe(u) + cfg_sb(u);
    endfunction

    // Line bits of one frame, index 0 = start bit; unused/stop positions are 1.
    function automatic logic [15:0] build_bits(int u, logic [8:0] w);
        logic [15:0] b;
        logic        p;
        b    = '1;
        b[0] = 1'b0;
        p    = (cfg_po(u) != 0);
        for (int i = 0; i < cfg_dw(u); i++) begin
            b[1 + i] = w[i];
            p        = p ^ w[i];
        end
        if (cfg_pe(u) != 0) b[1 + cfg_dw(u)] = p;
        return b;
    endfunction

    task automatic check_eq(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs as seen at each active edge.
    logic          rst_s;
    logic [NU-1:0] trmt_s;
    logic [8:0]    data_s [NU];
    always @(posedge clk) begin
        rst_s  <= rst;
        trmt_s <= trmt_v;
        for (int u = 0; u < NU; u++) data_s[u] <= data_v[u];
    end

    // Reference model state
    bit          model_live = 1'b0;
    bit          act    [NU];
    int          pos    [NU];
    bit          hf     [NU];
    logic [8:0]  hw     [NU];
    logic [15:0] bits_m [NU];
    bit          done_e [NU];

    task automatic model_step();
        bit acc;
        for (int u = 0; u < NU; u++) begin
            if (rst_s === 1'b1) begin
                act[u]    = 1'b0;
                hf[u]     = 1'b0;
                done_e[u] = 1'b0;
                pos[u]    = 0;
            end else begin
                done_e[u] = 1'b0;
                acc       = trmt_s[u] && !hf[u];
                if (act[u]) begin
                    pos[u]++;
                    if (pos[u] == cfg_nbits(u) * cfg_bd(u)) begin
                        act[u]    = 1'b0;
                        done_e[u] = 1'b1;
                    end
                end
                if (!act[u] && hf[u]) begin
                    act[u]    = 1'b1;
                    pos[u]    = 0;
                    bits_m[u] = build_bits(u, hw[u]);
                    hf[u]     = 1'b0;
                end
                if (acc) begin
                    hf[u] = 1'b1;
                    hw[u] = data_s[u];
                end
            end
        end
        if (rst_s === 1'b1) model_live = 1'b1;
    endtask

    // Compare every unit against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            cyc++;
            if (model_live) begin
                for (int u = 0; u < NU; u++) begin
                    check_eq($sformatf("u%0d tx cyc%0d", u, cyc), int'(tx_v[u]),
                             act[u] ? int'(bits_m[u][pos[u] / cfg_bd(u)]) : 1);
                    check_eq($sformatf("u%0d busy cyc%0d", u, cyc), int'(busy_v[u]), int'(act[u]));
                    check_eq($sformatf("u%0d tx_rdy cyc%0d", u, cyc), int'(rdy_v[u]), int'(!hf[u]));
                    check_eq($sformatf("u%0d tx_done cyc%0d", u, cyc), int'(done_v[u]), int'(done_e[u]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int u, logic [8:0] w);
        trmt_v[u] = 1'b1;
        data_v[u] = w;
        tick();
        trmt_v[u] = 1'b0;
        data_v[u] = 9'($urandom);
    endtask

    // Called right after an accept from idle: checks the frame bit by bit at mid-bit.
    task automatic expect_frame(int u, logic [15:0] lit, int nb, string name);
        int b;
        b = cfg_bd(u);
        tick();
        check_eq({name, " start"}, int'(tx_v[u]), 0);
        for (int c = 1; c <= nb * b; c++) begin
            tick();
            if (c % b == b / 2)
                check_eq($sformatf("%s bit%0d", name, c / b), int'(tx_v[u]), int'(lit[c / b]));
            if (c == nb * b) begin
                check_eq({name, " done"}, int'(done_v[u]), 1);
                check_eq({name, " busy_after"}, int'(busy_v[u]), 0);
            end
        end
        $display("frame %s unit %0d checked", name, u);
    endtask

    task automatic wait_done(int u, int maxc, string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_v[u] && n < maxc);
        check_eq({name, " wait"}, int'(done_v[u]), 1);
    endtask

    initial begin
        int n1, n2, seen;
        for (int u = 0; u < NU; u++) data_v[u] = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset tx", int'(tx_v[0]), 1);
        check_eq("reset rdy", int'(rdy_v[0]), 1);
        check_eq("reset busy", int'(busy_v[0]), 0);
        repeat (4) tick();

        // Basic frame 0xA5
        send(0, 9'h0A5);
        expect_frame(0, 16'b1101001010, 10, "a5");
        repeat (5) tick();

        // Parity even / odd on 0x07
        send(1, 9'h007);
        expect_frame(1, 16'b11000001110, 11, "par_even");
        send(2, 9'h007);
        expect_frame(2, 16'b10000001110, 11, "par_odd");
        repeat (5) tick();

        // Back-to-back with a dropped word while hold is full
        send(0, 9'h055);
        repeat (15) tick();
        send(0, 9'h00F);
        check_eq("b2b rdy_full", int'(rdy_v[0]), 0);
        send(0, 9'h0FF);
        check_eq("drop rdy", int'(rdy_v[0]), 0);
        wait_done(0, 400, "b2b first", n1);
        check_eq("b2b rdy_after_load", int'(rdy_v[0]), 1);
        check_eq("b2b busy_cont", int'(busy_v[0]), 1);
        wait_done(0, 400, "b2b second", n2);
        check_eq("b2b spacing", n2, 160);
        check_eq("b2b idle", int'(busy_v[0]), 0);
        $display("back-to-back 0x55/0x0F spacing %0d", n2);
        repeat (5) tick();

        // 7 data bits, 2 stop bits
        send(3, 9'h07F);
        expect_frame(3, 16'b1111111110, 10, "dw7_sb2");
        repeat (5) tick();

        // Reset during data bit 3 with a word queued
        send(0, 9'h012);
        tick();
        send(0, 9'h034);
        repeat (70) tick();
        check_eq("mid busy", int'(busy_v[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst tx", int'(tx_v[0]), 1);
        check_eq("rst rdy", int'(rdy_v[0]), 1);
        check_eq("rst busy", int'(busy_v[0]), 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_v[0]) seen++;
            tick();
        end
        check_eq("rst no_done", seen, 0);
        send(0, 9'h03C);
        expect_frame(0, 16'b1001111000, 10, "after_rst_3c");

        // Randomised traffic on every unit with occasional reset
        for (int t = 0; t < 6000; t++) begin
            for (int u = 0; u < NU; u++) begin
                trmt_v[u] = ($urandom_range(0, 3) == 0);
                data_v[u] = 9'($urandom);
            end
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        trmt_v = '0;
        rst    = 1'b0;
        repeat (600) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
